credit_send: RTL and testbench

Transmit end of a credit-based link feeding a downstream bank of per-VC register queues. Accepts messages from `num_vcs` upstream en/rdy channels, arbitrates round-robin among VCs that hold credits, drives one registered message per cycle onto the link, and maintains one credit counter per VC mirroring the free entries of the matching downstream queue. The receiver returns one credit per VC whenever it dequeues an entry.

---
 rtl/credit_pkg.sv | 18 +
 rtl/round_robin_arbiter.sv | 43 ++++
 rtl/credit_send.sv | 119 +++++++++++
 tb/tb_credit_send.sv | 135 +++++++++++++
 4 files changed

// File: rtl/credit_pkg.sv
// Shared types and width helpers for the credit-based link transmitter.
package credit_pkg;

  function automatic int calc_vc_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int calc_cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int default_num_vcs     = 2;
  localparam int default_credit_line = 2;

  typedef logic [calc_vc_width(default_num_vcs)-1:0]      vc_idx_t;
  typedef logic [calc_cnt_width(default_credit_line)-1:0] credit_cnt_t;

endpackage

// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after prio_reg.
module round_robin_arbiter
  import credit_pkg::*;
#(
  parameter int n = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [n-1:0] req,
  input  logic         prio_en,
  output logic [n-1:0] grant
);

  localparam int pw = calc_vc_width(n);

  logic [pw-1:0] prio_reg;
  logic [pw-1:0] prio_next;

  // Scan offsets from the far end so the nearest requester is written last and wins.
  always_comb begin
    int idx;
    grant     = '0;
    prio_next = prio_reg;
    idx       = 0;
    for (int off = n - 1; off >= 0; off--) begin
      idx = (int'(prio_reg) + off) % n;
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        prio_next  = pw'((idx + 1) % n);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prio_reg <= '0;
    end else if (prio_en) begin
      prio_reg <= prio_next;
    end
  end

endmodule

// File: rtl/credit_send.sv
// Credit-based link transmitter: per-VC credit counters, round-robin grant, registered link output.
module credit_send
  import credit_pkg::*;
#(
  parameter int data_width  = 32,
  parameter int num_vcs     = 2,
  parameter int credit_line = 2,
  parameter int vc_width    = calc_vc_width(num_vcs),
  parameter int cnt_width   = calc_cnt_width(credit_line)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [num_vcs-1:0]             recv_en,
  output logic [num_vcs-1:0]             recv_rdy,
  input  logic [num_vcs*data_width-1:0]  recv_msg,
  output logic                           send_en,
  output logic [vc_width-1:0]            send_vc,
  output logic [data_width-1:0]          send_msg,
  input  logic                           credit_en,
  input  logic [vc_width-1:0]            credit_vc,
  output logic [num_vcs*cnt_width-1:0]   credit_cnt
);

  localparam logic [cnt_width-1:0] full_cnt = cnt_width'(credit_line);

  logic [cnt_width-1:0]  cnt_reg [num_vcs];
  logic [num_vcs-1:0]    eligible;
  logic [num_vcs-1:0]    grant;
  logic [num_vcs-1:0]    accept;

  logic                  send_en_reg;
  logic [vc_width-1:0]   send_vc_reg;
  logic [data_width-1:0] send_msg_reg;
  logic [vc_width-1:0]   sel_vc_next;
  logic [data_width-1:0] sel_msg_next;

  round_robin_arbiter #(.n(num_vcs)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (eligible),
    .prio_en (|grant),
    .grant   (grant)
  );

  assign recv_rdy = grant;
  assign accept   = recv_en & grant;

  genvar gi;
  generate
    for (gi = 0; gi < num_vcs; gi++) begin : g_vc
      logic take;
      logic give;

      assign take         = accept[gi];
      assign give         = credit_en && (credit_vc == vc_width'(gi));
      assign eligible[gi] = (cnt_reg[gi] != '0);
      assign credit_cnt[gi*cnt_width +: cnt_width] = cnt_reg[gi];

      // Simultaneous take and give cancel; a give at full saturates.
      always_ff @(posedge clk) begin
        if (reset) begin
          cnt_reg[gi] <= full_cnt;
        end else if (take && !give) begin
          cnt_reg[gi] <= cnt_reg[gi] - 1'b1;
        end else if (give && !take && (cnt_reg[gi] != full_cnt)) begin
          cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
        end
      end

`ifndef SYNTHESIS
      always_ff @(posedge clk) begin
        if (!reset) begin
          assert (!(give && !take && (cnt_reg[gi] == full_cnt)))
            else $error("credit returned to full counter on vc %0d", gi);
        end
      end
`endif
    end
  endgenerate

  always_comb begin
    sel_vc_next  = '0;
    sel_msg_next = '0;
    for (int v = 0; v < num_vcs; v++) begin
      if (accept[v]) begin
        sel_vc_next  = vc_width'(v);
        sel_msg_next = recv_msg[v*data_width +: data_width];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      send_en_reg  <= 1'b0;
      send_vc_reg  <= '0;
      send_msg_reg <= '0;
    end else begin
      send_en_reg <= |accept;
      if (|accept) begin
        send_vc_reg  <= sel_vc_next;
        send_msg_reg <= sel_msg_next;
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert ((recv_en & ~grant) == '0)
        else $error("recv_en asserted without recv_rdy: en=%b rdy=%b", recv_en, grant);
    end
  end
`endif

  assign send_en  = send_en_reg;
  assign send_vc  = send_vc_reg;
  assign send_msg = send_msg_reg;

endmodule

// File: tb/tb_credit_send.sv
// Directed bench for credit_send: cycle table of inputs and expected outputs, plus a reset-mid-stream sequence.
module tb_credit_send;
  import credit_pkg::*;

  logic        clk;
  logic        reset;
  logic [1:0]  recv_en;
  logic [1:0]  recv_rdy;
  logic [63:0] recv_msg;
  logic        send_en;
  vc_idx_t     send_vc;
  logic [31:0] send_msg;
  logic        credit_en;
  vc_idx_t     credit_vc;
  logic [3:0]  credit_cnt;

  int checks = 0;
  int errors = 0;

  credit_send #(.data_width(32), .num_vcs(2), .credit_line(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .recv_en    (recv_en),
    .recv_rdy   (recv_rdy),
    .recv_msg   (recv_msg),
    .send_en    (send_en),
    .send_vc    (send_vc),
    .send_msg   (send_msg),
    .credit_en  (credit_en),
    .credit_vc  (credit_vc),
    .credit_cnt (credit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  en;
    logic [31:0] m0;
    logic [31:0] m1;
    logic        cen;
    logic        cvc;
    logic [1:0]  rdy;
    logic        sen;
    logic        svc;
    logic [31:0] smsg;
    logic [3:0]  cnt;
  } vec_t;

  vec_t vecs [16];

  function automatic vec_t mk(logic [1:0] en, logic [31:0] m0, logic [31:0] m1,
                              logic cen, logic cvc, logic [1:0] rdy, logic sen,
                              logic svc, logic [31:0] smsg, logic [3:0] cnt);
    vec_t v;
    v.en = en; v.m0 = m0; v.m1 = m1; v.cen = cen; v.cvc = cvc;
    v.rdy = rdy; v.sen = sen; v.svc = svc; v.smsg = smsg; v.cnt = cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input int cyc, input logic [1:0] rdy, input logic sen,
                           input logic svc, input logic [31:0] smsg, input logic [3:0] cnt);
    check($sformatf("c%0d recv_rdy", cyc), 32'(recv_rdy), 32'(rdy));
    check($sformatf("c%0d send_en", cyc), 32'(send_en), 32'(sen));
    check($sformatf("c%0d send_vc", cyc), 32'(send_vc), 32'(svc));
    check($sformatf("c%0d send_msg", cyc), send_msg, smsg);
    check($sformatf("c%0d credit_cnt", cyc), 32'(credit_cnt), 32'(cnt));
    $display("cycle %0d: rdy=%b send_en=%b vc=%0d msg=%h cnt=%h", cyc, recv_rdy, send_en,
             send_vc, send_msg, credit_cnt);
  endtask

  localparam logic [31:0] J0 = 32'h5555_0000;
  localparam logic [31:0] J1 = 32'h5555_0001;

  initial begin
    // cnt column is {credit[1], credit[0]}, two bits each.
    //            en     m0      m1     cen  cvc   rdy    sen  svc  smsg    cnt
    vecs[0]  = mk(2'b00, J0,     J1,    0,   0,    2'b01, 0,   0,   32'h0,  4'hA);
    vecs[1]  = mk(2'b00, J0,     J1,    0,   0,    2'b10, 0,   0,   32'h0,  4'hA);
    vecs[2]  = mk(2'b01, 32'hA1, J1,    0,   0,    2'b01, 0,   0,   32'h0,  4'hA);
    vecs[3]  = mk(2'b00, J0,     J1,    0,   0,    2'b10, 1,   0,   32'hA1, 4'h9);
    vecs[4]  = mk(2'b01, 32'hA2, J1,    0,   0,    2'b01, 0,   0,   32'hA1, 4'h9);
    vecs[5]  = mk(2'b00, J0,     J1,    0,   0,    2'b10, 1,   0,   32'hA2, 4'h8);
    vecs[6]  = mk(2'b00, J0,     J1,    0,   0,    2'b10, 0,   0,   32'hA2, 4'h8);
    vecs[7]  = mk(2'b00, J0,     J1,    1,   0,    2'b10, 0,   0,   32'hA2, 4'h8);
    vecs[8]  = mk(2'b00, J0,     J1,    0,   0,    2'b01, 0,   0,   32'hA2, 4'h9);
    vecs[9]  = mk(2'b00, J0,     J1,    1,   0,    2'b10, 0,   0,   32'hA2, 4'h9);
    vecs[10] = mk(2'b01, 32'hB0, J1,    0,   0,    2'b01, 0,   0,   32'hA2, 4'hA);
    vecs[11] = mk(2'b10, J0,     32'hC0, 1,  0,    2'b10, 1,   0,   32'hB0, 4'h9);
    vecs[12] = mk(2'b01, 32'hB1, J1,    1,   1,    2'b01, 1,   1,   32'hC0, 4'h6);
    vecs[13] = mk(2'b10, J0,     32'hC1, 1,  1,    2'b10, 1,   0,   32'hB1, 4'h9);
    vecs[14] = mk(2'b01, 32'hB2, J1,    0,   0,    2'b01, 1,   1,   32'hC1, 4'h9);
    vecs[15] = mk(2'b10, J0,     32'hC2, 0,  0,    2'b10, 1,   0,   32'hB2, 4'h8);

    reset     = 1'b1;
    recv_en   = '0;
    recv_msg  = '0;
    credit_en = 1'b0;
    credit_vc = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      check_all(i, vecs[i].rdy, vecs[i].sen, vecs[i].svc, vecs[i].smsg, vecs[i].cnt);
      recv_en   = vecs[i].en;
      recv_msg  = {vecs[i].m1, vecs[i].m0};
      credit_en = vecs[i].cen;
      credit_vc = vc_idx_t'(vecs[i].cvc);
      @(negedge clk);
    end

    // Reset while a message is on the link and credits are {vc1=1, vc0=0}.
    check_all(16, 2'b10, 1'b1, 1'b1, 32'hC2, 4'h4);
    reset     = 1'b1;
    recv_en   = 2'b10;
    recv_msg  = {32'hC3, J0};
    credit_en = 1'b0;
    @(negedge clk);
    recv_en = '0;
    check_all(17, 2'b01, 1'b0, 1'b0, 32'h0, 4'hA);
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
